vlc_tx_lanes: RTL and testbench

Parametrised multi-lane VLC transmitter, the next generation of the single-lane send path. It accepts 32-bit words from the Avalon read master through a valid/ready stream and buffers them in an internal FIFO. It frames and serialises the words across `LANES` optical GPIO lanes in NRZ or Manchester coding at a programmable symbol rate. It emits the start-receive hand-off pulse and a done/underrun status to the CSR block.

---
 rtl/vlc_pkg.sv | 20 ++
 rtl/vlc_fifo.sv | 72 +++++++
 rtl/vlc_tx_lanes.sv | 261 ++++++++++++++++++++++++++
 tb/tb_vlc_tx_lanes.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared types and constants for the multi-lane VLC transmitter.
package vlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  localparam logic [7:0] PREAMBLE = 8'hAA;
  localparam int         PRE_LEN  = 8;

  // Line coding of one bit for the given half of its bit period.
  // Manchester sends ~b then b, so a 1 is a low-to-high transition.
  function automatic logic line_code(input logic b, input logic man, input logic second_half);
    return man ? (second_half ? b : ~b) : b;
  endfunction

endpackage

// File: rtl/vlc_fifo.sv
// Synchronous word FIFO with flush, show-ahead read data and occupancy count.
module vlc_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy update; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vlc_tx_lanes.sv
// Multi-lane VLC transmitter: buffers words, sends preamble, data and stop bit
// across LANES optical outputs in NRZ or Manchester coding.
module vlc_tx_lanes
  import vlc_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iStart,
  input  logic [31:0]       iLength,
  input  logic [DIV_W-1:0]  iDiv,
  input  logic              iManchester,
  input  logic [DATA_W-1:0] iWord,
  input  logic              iWord_valid,
  output logic              oWord_ready,
  output logic [LANES-1:0]  oLane,
  output logic              oBusy,
  output logic              oStart_rx,
  output logic              oDone,
  output logic              oUnderrun
);

  localparam int S     = DATA_W / LANES;
  localparam int BIT_W = ($clog2(S) + 1 < 4) ? 4 : $clog2(S) + 1;
  localparam int IW    = $clog2(DATA_W);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   slot_q, slot_d;
  logic               half_q, half_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [31:0]        len_q, len_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               man_q, man_d;
  logic [31:0]        sent_q, sent_d;
  logic [31:0]        acc_q, acc_d;
  logic [LANES-1:0]   lane_q, lane_d;
  logic               srx_q, srx_d;
  logic               done_q, done_d;
  logic               under_q, under_d;

  logic               fifo_flush, fifo_push, fifo_pop;
  logic [DATA_W-1:0]  fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               fifo_count_unused;
  logic               sym_end, bit_end;

  // Preamble bit idx, MSB first.
  function automatic logic pre_bit(input logic [BIT_W-1:0] idx);
    logic [2:0] pi;
    pi = 3'(PRE_LEN - 1) - 3'(idx);
    return PREAMBLE[pi];
  endfunction

  // Lane k carries word bits [k*S+S-1 : k*S], MSB first.
  function automatic logic [LANES-1:0] data_lanes(input logic [DATA_W-1:0] w,
                                                  input logic [BIT_W-1:0]  idx,
                                                  input logic              man,
                                                  input logic              second_half);
    logic [LANES-1:0] r;
    logic [IW-1:0]    pos;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      pos  = IW'(k * S + S - 1) - IW'(idx);
      r[k] = line_code(w[pos], man, second_half);
    end
    return r;
  endfunction

  vlc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (iWord),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign fifo_count_unused = ^fifo_count;

  assign oBusy       = (state_q != ST_IDLE);
  assign oWord_ready = oBusy && !fifo_full && (acc_q < len_q);
  assign fifo_push   = iWord_valid && oWord_ready;
  assign oLane       = lane_q;
  assign oStart_rx   = srx_q;
  assign oDone       = done_q;
  assign oUnderrun   = under_q;

  assign sym_end = (slot_q == div_q);
  assign bit_end = sym_end && (!man_q || half_q);

  // Next-state, slot/bit sequencing and next lane value.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    half_d     = half_q;
    bit_d      = bit_q;
    word_d     = word_q;
    len_d      = len_q;
    div_d      = div_q;
    man_d      = man_q;
    sent_d     = sent_q;
    acc_d      = fifo_push ? acc_q + 32'd1 : acc_q;
    lane_d     = lane_q;
    srx_d      = 1'b0;
    done_d     = 1'b0;
    under_d    = under_q;
    fifo_flush = 1'b0;
    fifo_pop   = 1'b0;

    if (state_q != ST_IDLE) slot_d = sym_end ? '0 : slot_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        lane_d = '0;
        if (iStart) begin
          if (iLength != 32'd0) begin
            len_d      = iLength;
            div_d      = iDiv;
            man_d      = iManchester;
            under_d    = 1'b0;
            fifo_flush = 1'b1;
            acc_d      = '0;
            sent_d     = '0;
            slot_d     = '0;
            half_d     = 1'b0;
            bit_d      = '0;
            state_d    = ST_PRE;
            lane_d     = {LANES{line_code(PREAMBLE[PRE_LEN-1], iManchester, 1'b0)}};
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_PRE: begin
        if (sym_end) begin
          if (!bit_end) begin
            half_d = 1'b1;
            lane_d = {LANES{line_code(pre_bit(bit_q), man_q, 1'b1)}};
          end else if (bit_q == BIT_W'(PRE_LEN - 1)) begin
            half_d = 1'b0;
            bit_d  = '0;
            if (fifo_empty) begin
              under_d = 1'b1;
              state_d = ST_STOP;
              lane_d  = '0;
            end else begin
              fifo_pop = 1'b1;
              word_d   = fifo_rdata;
              srx_d    = 1'b1;
              state_d  = ST_DATA;
              lane_d   = data_lanes(fifo_rdata, '0, man_q, 1'b0);
            end
          end else begin
            half_d = 1'b0;
            bit_d  = bit_q + BIT_W'(1);
            lane_d = {LANES{line_code(pre_bit(bit_q + BIT_W'(1)), man_q, 1'b0)}};
          end
        end
      end

      ST_DATA: begin
        if (sym_end) begin
          if (!bit_end) begin
            half_d = 1'b1;
            lane_d = data_lanes(word_q, bit_q, man_q, 1'b1);
          end else if (bit_q == BIT_W'(S - 1)) begin
            half_d = 1'b0;
            bit_d  = '0;
            sent_d = sent_q + 32'd1;
            if (sent_q + 32'd1 == len_q) begin
              state_d = ST_STOP;
              lane_d  = '0;
            end else if (fifo_empty) begin
              under_d = 1'b1;
              state_d = ST_STOP;
              lane_d  = '0;
            end else begin
              fifo_pop = 1'b1;
              word_d   = fifo_rdata;
              lane_d   = data_lanes(fifo_rdata, '0, man_q, 1'b0);
            end
          end else begin
            half_d = 1'b0;
            bit_d  = bit_q + BIT_W'(1);
            lane_d = data_lanes(word_q, bit_q + BIT_W'(1), man_q, 1'b0);
          end
        end
      end

      ST_STOP: begin
        lane_d = '0;
        if (bit_end) begin
          state_d = ST_IDLE;
          half_d  = 1'b0;
          done_d  = 1'b1;
        end else if (sym_end) begin
          half_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        lane_d  = '0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      man_q   <= 1'b0;
      sent_q  <= '0;
      acc_q   <= '0;
      lane_q  <= '0;
      srx_q   <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      div_q   <= div_d;
      man_q   <= man_d;
      sent_q  <= sent_d;
      acc_q   <= acc_d;
      lane_q  <= lane_d;
      srx_q   <= srx_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  // Word being serialised.
  always_ff @(posedge clock) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_vlc_tx_lanes.sv
// Scoreboard bench for vlc_tx_lanes (4 lanes): a frame-level model predicts the
// per-cycle lane trace and end-of-frame status; a monitor compares them.
module tb_vlc_tx_lanes;

  localparam int LANES      = 4;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int S          = DATA_W / LANES;
  localparam int IW         = $clog2(DATA_W);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              iStart = 1'b0;
  logic [31:0]       iLength = '0;
  logic [DIV_W-1:0]  iDiv = '0;
  logic              iManchester = 1'b0;
  logic [DATA_W-1:0] iWord = '0;
  logic              iWord_valid = 1'b0;
  logic              oWord_ready;
  logic [LANES-1:0]  oLane;
  logic              oBusy, oStart_rx, oDone, oUnderrun;

  vlc_tx_lanes #(
    .LANES      (LANES),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iStart      (iStart),
    .iLength     (iLength),
    .iDiv        (iDiv),
    .iManchester (iManchester),
    .iWord       (iWord),
    .iWord_valid (iWord_valid),
    .oWord_ready (oWord_ready),
    .oLane       (oLane),
    .oBusy       (oBusy),
    .oStart_rx   (oStart_rx),
    .oDone       (oDone),
    .oUnderrun   (oUnderrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [LANES-1:0] lane;
    logic             srx;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_done_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  bit   model_under = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One bit period: halves x (div+1) clocks.
  task automatic add_bit(input logic [LANES-1:0] v, input bit srx, input bit stop,
                         input bit man, input int div, inout int cnt);
    exp_t e;
    for (int h = 0; h < (man ? 2 : 1); h++) begin
      for (int c = 0; c <= div; c++) begin
        e.lane = stop ? '0 : ((man && h == 0) ? ~v : v);
        e.srx  = srx && (h == 0) && (c == 0);
        exp_q.push_back(e);
        cnt++;
      end
    end
  endtask

  // Frame model: preamble, min(navail,len) words, then a zero stop bit.
  task automatic model_frame(input int len, input int div, input bit man, input int navail,
                             input logic [DATA_W-1:0] wl[$], output int ncyc);
    int nw, cnt;
    logic [7:0] pre;
    logic [DATA_W-1:0] cur;
    logic [LANES-1:0] v;
    cnt = 0;
    if (len == 0) begin
      exp_done_q.push_back(model_under);
      ncyc = 1;
      return;
    end
    nw  = (navail < len) ? navail : len;
    pre = 8'hAA;
    for (int i = 0; i < 8; i++) add_bit({LANES{pre[3'(7 - i)]}}, 1'b0, 1'b0, man, div, cnt);
    for (int wi = 0; wi < nw; wi++) begin
      cur = wl[wi];
      for (int j = 0; j < S; j++) begin
        for (int k = 0; k < LANES; k++) v[k] = cur[IW'(k * S + S - 1 - j)];
        add_bit(v, (wi == 0) && (j == 0), 1'b0, man, div, cnt);
      end
    end
    add_bit('0, 1'b0, 1'b1, man, div, cnt);
    model_under = (navail < len);
    exp_done_q.push_back(model_under);
    ncyc = cnt + 1;
  endtask

  // Monitor: compares every cycle against the scoreboard.
  exp_t mon_e;
  bit   prev_busy = 1'b0;
  bit   last_under = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_busy  = 1'b0;
      last_under = 1'b0;
    end else begin
      if (oBusy) begin
        check("done_while_busy", 64'(oDone), 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_busy: got busy=1, expected idle (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("lane", 64'(oLane), 64'(mon_e.lane));
          check("start_rx", 64'(oStart_rx), 64'(mon_e.srx));
        end
      end else begin
        check("idle_lane", 64'(oLane), 64'd0);
        check("idle_start_rx", 64'(oStart_rx), 64'd0);
        check("idle_ready", 64'(oWord_ready), 64'd0);
        if (prev_busy) check("done_at_frame_end", 64'(oDone), 64'd1);
        if (oDone) begin
          if (exp_done_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected none (t=%0t)", $time);
          end else begin
            last_under = exp_done_q.pop_front();
            check("underrun_at_done", 64'(oUnderrun), 64'(last_under));
            check("trace_consumed", 64'(exp_q.size()), 64'd0);
          end
          done_seen++;
        end else begin
          check("underrun_sticky", 64'(oUnderrun), 64'(last_under));
        end
      end
      prev_busy = oBusy;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lane"},     64'(oLane), 64'd0);
    check({tag, "_ready"},    64'(oWord_ready), 64'd0);
    check({tag, "_busy"},     64'(oBusy), 64'd0);
    check({tag, "_start_rx"}, 64'(oStart_rx), 64'd0);
    check({tag, "_done"},     64'(oDone), 64'd0);
    check({tag, "_underrun"}, 64'(oUnderrun), 64'd0);
  endtask

  // Drives one frame from posedge+1; ghost_at/rst_at (cycle index, 0 = off)
  // inject an ignored iStart or an asynchronous reset during the frame.
  task automatic run_frame(input int len, input int div, input bit man, input int navail,
                           input logic [DATA_W-1:0] wl_in[$], input int ghost_at, input int rst_at);
    logic [DATA_W-1:0] wl[$];
    int exp_cyc, idx, start_done, cyc, nacc;
    bit hs, ended;
    wl = wl_in;
    while (wl.size() < navail) wl.push_back($urandom);
    model_frame(len, div, man, navail, wl, exp_cyc);
    start_done = done_seen;
    idx   = 0;
    ended = 1'b0;
    iStart      = 1'b1;
    iLength     = len;
    iDiv        = DIV_W'(div);
    iManchester = man;
    iWord_valid = (navail > 0);
    iWord       = '0;
    if (navail > 0) iWord = wl[0];
    @(negedge clock); #1;
    hs = iWord_valid && oWord_ready;
    for (cyc = 1; cyc < 4000; cyc++) begin
      @(posedge clock); #1;
      if (hs) idx++;
      iStart = (cyc == ghost_at);
      if (cyc == ghost_at) begin
        iLength     = len + 2;
        iDiv        = DIV_W'(div + 1);
        iManchester = ~man;
      end
      if (cyc == rst_at) begin
        reset = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        exp_q.delete();
        exp_done_q.delete();
        model_under = 1'b0;
        iWord_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        ended = 1'b1;
        break;
      end
      iWord_valid = (idx < navail);
      if (idx < navail) iWord = wl[idx];
      @(negedge clock); #1;
      hs = iWord_valid && oWord_ready;
      if (done_seen != start_done) begin
        ended = 1'b1;
        break;
      end
    end
    iStart      = 1'b0;
    iWord_valid = 1'b0;
    if (!ended) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_timeout: got no done after %0d cycles, expected %0d", cyc, exp_cyc);
    end else if (rst_at == 0) begin
      nacc = (navail < len) ? navail : len;
      check("frame_cycles", 64'(cyc), 64'(exp_cyc));
      check("words_accepted", 64'(idx), 64'(nacc));
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [DATA_W-1:0] w[$];
    int len, div, mode, navail;
    bit man;

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Four-lane split of two contiguous words, NRZ, one clock per slot.
    w = '{32'h12345678, 32'h9ABCDEF0};
    run_frame(2, 0, 1'b0, 2, w, 0, 0);

    // Manchester with two-clock slots.
    w = '{32'hF0F0A55A};
    run_frame(1, 1, 1'b1, 1, w, 0, 0);

    // Zero-length start.
    w = {};
    run_frame(0, 0, 1'b0, 0, w, 0, 0);

    // Underrun after the first of three words.
    w = '{32'hCAFEF00D};
    run_frame(3, 0, 1'b0, 1, w, 0, 0);

    // Next frame clears the sticky underrun.
    w = '{32'h0F1E2D3C};
    run_frame(1, 2, 1'b0, 1, w, 0, 0);

    // Underrun before any data word.
    w = {};
    run_frame(2, 0, 1'b1, 0, w, 0, 0);

    // Ignored iStart during DATA.
    w = '{32'hDEADBEEF, 32'h01234567};
    run_frame(2, 1, 1'b0, 2, w, 30, 0);

    // Extra words offered beyond the length.
    w = {};
    run_frame(2, 0, 1'b0, 5, w, 0, 0);

    // Reset mid-DATA, then a clean frame.
    w = {};
    run_frame(3, 0, 1'b0, 3, w, 0, 15);
    repeat (2) @(posedge clock);
    #1;
    w = '{32'hA5A5C3C3};
    run_frame(1, 0, 1'b1, 1, w, 0, 0);

    // Randomized frames.
    for (int t = 0; t < 10; t++) begin
      len  = $urandom_range(5, 1);
      div  = $urandom_range(3, 0);
      man  = $urandom_range(1, 0);
      mode = $urandom_range(4, 0);
      if (mode == 0)      navail = $urandom_range(len - 1, 0);
      else if (mode == 1) navail = len + 2;
      else                navail = len;
      w = {};
      run_frame(len, div, man, navail, w, 0, 0);
    end

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
